// File: rtl/pingpong_read_ctrl_pkg.sv
// Shared definitions for the ping-pong read controller: FSM encoding, bank
// indices, debug view and the frame-length clamp.
package pingpong_read_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_READ    = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

    typedef struct packed {
        logic [1:0] state;
        logic       cur;
        logic       fifo_full;
        logic [1:0] fifo_count;
    } dbg_t;

    // A bank never holds more than depth words, whatever the write side reports.
    function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/pingpong_read_ctrl_if.sv
// Downstream frame stream. Handshake: a word transfers on a rising clk edge where
// m_valid_o && m_ready_i; once m_valid_o is high, m_data_o/m_last_o hold until accepted.
interface pingpong_read_ctrl_if #(
    parameter int DATA_W = 32
) ();
    logic              m_valid_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_last_o;
    logic              m_ready_i;

    modport master (
        output m_valid_o,
        output m_data_o,
        output m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  m_valid_o,
        input  m_data_o,
        input  m_last_o,
        output m_ready_i
    );
endinterface

// File: rtl/pingpong_read_ctrl_skid_fifo.sv
// Two-entry skid FIFO holding RAM read data plus its last tag until the
// downstream consumer accepts it. Push and pop may happen in the same cycle.
module pingpong_skid_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // When full, a same-cycle pop frees the slot the push lands in.
    assign w_push = i_wr_en && (!o_full || i_rd_en);
    assign w_pop  = i_rd_en && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pingpong_read_ctrl.sv
// Read side of the ping-pong buffer: drains banks 0,1,0,... from a 1-cycle-latency
// RAM into a framed valid/ready stream and pulses a release once a bank is drained.
module pingpong_read_ctrl
    import pingpong_read_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           bank_full_i,
    input  logic [ADDR_W:0]      bank0_len_i,
    input  logic [ADDR_W:0]      bank1_len_i,
    output logic [1:0]           bank_release_o,
    output logic                 rd_en_o,
    output logic                 rd_bank_o,
    output logic [ADDR_W-1:0]    rd_addr_o,
    input  logic [DATA_W-1:0]    rd_data_i,
    pingpong_read_ctrl_if.master m_if,
    output dbg_t                 dbg_o
);
    localparam int LEN_W = ADDR_W + 1;

    logic [1:0]        r_state;
    logic              r_cur;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_addr;
    logic              r_inflight;
    logic              r_inflight_last;

    logic              w_full_cur;
    logic [LEN_W-1:0]  w_len_sel;
    logic [LEN_W-1:0]  w_len_clamped;
    logic              w_is_last_addr;
    logic              w_rd_en;
    logic              w_pop;
    logic              w_last_acc;
    logic [2:0]        w_credit_used;
    logic [DATA_W:0]   w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [1:0]        w_fifo_count;

    assign w_full_cur     = bank_full_i[r_cur];
    assign w_len_sel      = (r_cur == BANK1) ? bank1_len_i : bank0_len_i;
    assign w_len_clamped  = LEN_W'(clamp_len(16'(w_len_sel), 16'(DEPTH)));
    assign w_is_last_addr = ({1'b0, r_addr} == (r_len - LEN_W'(1)));

    assign w_pop      = !w_fifo_empty && m_if.m_ready_i;
    assign w_last_acc = w_pop && w_head[DATA_W];

    // A word leaving this cycle frees its slot, which keeps one read per cycle
    // flowing under full throughput while the FIFO still never overflows.
    assign w_credit_used = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en       = (r_state == ST_READ) && (w_credit_used < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cur           <= BANK0;
            r_len           <= '0;
            r_addr          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_rd_en;
            r_inflight_last <= w_rd_en && w_is_last_addr;
            case (r_state)
                ST_IDLE: begin
                    if (w_full_cur) begin
                        r_len   <= w_len_clamped;
                        r_addr  <= '0;
                        r_state <= (w_len_clamped == '0) ? ST_RELEASE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_rd_en) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        if (w_is_last_addr) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_last_acc) begin
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    r_cur   <= ~r_cur;
                    r_addr  <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    pingpong_skid_fifo #(
        .W (DATA_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (r_inflight),
        .i_wr_data ({r_inflight_last, rd_data_i}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign rd_en_o   = w_rd_en;
    assign rd_bank_o = r_cur;
    assign rd_addr_o = r_addr;

    assign bank_release_o = (r_state != ST_RELEASE) ? 2'b00 :
                            (r_cur == BANK1)        ? 2'b10 : 2'b01;

    assign m_if.m_valid_o = !w_fifo_empty;
    assign m_if.m_data_o  = w_head[DATA_W-1:0];
    assign m_if.m_last_o  = !w_fifo_empty && w_head[DATA_W];

    always_comb begin
        dbg_o            = '0;
        dbg_o.state      = r_state;
        dbg_o.cur        = r_cur;
        dbg_o.fifo_full  = w_fifo_full;
        dbg_o.fifo_count = w_fifo_count;
    end

endmodule

// File: tb/tb_pingpong_read_ctrl.sv
// Bench for pingpong_read_ctrl: directed frames against a RAM model, with an
// expected-beat queue and an expected-release queue drained by a negedge monitor.
module tb_pingpong_read_ctrl;
    import pingpong_read_ctrl_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        bank_full;
    logic [ADDR_W:0]   len0;
    logic [ADDR_W:0]   len1;
    logic [1:0]        bank_release;
    logic              rd_en;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    dbg_t              dbg;

    pingpong_read_ctrl_if #(.DATA_W(DATA_W)) m_if ();

    pingpong_read_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bank_full_i    (bank_full),
        .bank0_len_i    (len0),
        .bank1_len_i    (len1),
        .bank_release_o (bank_release),
        .rd_en_o        (rd_en),
        .rd_bank_o      (rd_bank),
        .rd_addr_o      (rd_addr),
        .rd_data_i      (rd_data),
        .m_if           (m_if),
        .dbg_o          (dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    bit rand_ready = 1'b0;

    logic [DATA_W:0] exp_q[$];
    logic [1:0]      rel_q[$];

    function automatic logic [31:0] ram_word(input int bank, input int addr);
        return {16'hA000 + 16'(bank), 16'(addr)};
    endfunction

    // RAM model: 1-cycle read latency
    always @(posedge clk) begin
        if (rd_en) rd_data <= ram_word(int'(rd_bank), int'(rd_addr));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_frame(input int bank, input int beats);
        for (int i = 0; i < beats; i++) begin
            exp_q.push_back({(i == beats - 1), ram_word(bank, i)});
        end
        rel_q.push_back((bank == 1) ? 2'b10 : 2'b01);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || rel_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, (exp_q.size() == 0 && rel_q.size() == 0), 1);
        exp_q.delete();
        rel_q.delete();
    endtask

    task automatic run_frame(input string name, input int bank, input int len, input int beats);
        @(posedge clk); #1;
        if (bank == 1) len1 = (ADDR_W+1)'(len); else len0 = (ADDR_W+1)'(len);
        bank_full[bank] = 1'b1;
        push_frame(bank, beats);
        wait_done(name, 3000);
        @(posedge clk); #1;
        bank_full = 2'b00;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bank_full = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) m_if.m_ready_i = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic            hold_pend = 1'b0;
        logic [DATA_W:0] hold_word = '0;
        logic [DATA_W:0] w;
        int              outstanding = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend   = 1'b0;
                outstanding = 0;
            end else begin
                if (hold_pend) begin
                    check("stall_valid", m_if.m_valid_o, 1);
                    check("stall_data", {m_if.m_last_o, m_if.m_data_o}, hold_word);
                end
                hold_pend = m_if.m_valid_o && !m_if.m_ready_i;
                hold_word = {m_if.m_last_o, m_if.m_data_o};
                outstanding = outstanding + int'(rd_en) - int'(m_if.m_valid_o && m_if.m_ready_i);
                check("outstanding_le2", (outstanding <= 2), 1);
                if (m_if.m_valid_o && m_if.m_ready_i) begin
                    n_acc++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no beat at %0t",
                                 {m_if.m_last_o, m_if.m_data_o}, $time);
                    end else begin
                        w = exp_q.pop_front();
                        check("beat", {m_if.m_last_o, m_if.m_data_o}, w);
                    end
                end
                if (bank_release != 2'b00) begin
                    if (rel_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_release: got %b, expected none at %0t",
                                 bank_release, $time);
                    end else begin
                        check("release", bank_release, rel_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 1ms");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int d;
        int n;
        int base;

        rst = 1'b1;
        bank_full = 2'b00;
        len0 = '0;
        len1 = '0;
        m_if.m_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid",   m_if.m_valid_o, 0);
        check("rst_data",    m_if.m_data_o, 0);
        check("rst_last",    m_if.m_last_o, 0);
        check("rst_rd_en",   rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_bank", rd_bank, 0);
        check("rst_release", bank_release, 0);
        check("rst_state",   dbg.state, ST_IDLE);
        @(posedge clk); #1;
        rst = 1'b0;
        m_if.m_ready_i = 1'b1;

        // Single frame, bank 0, len 4: latency, throughput, release, next bank
        @(posedge clk); #1;
        len0 = 9'd4;
        bank_full = 2'b01;
        push_frame(0, 4);
        @(negedge clk);
        check("lat_rd_en_idle", rd_en, 0);
        lat = 0;
        while (lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                check("lat_rd_en", rd_en, 1);
                check("lat_rd_addr", rd_addr, 0);
            end
            if (m_if.m_valid_o) break;
        end
        check("lat_first_valid", lat, 3);
        for (int k = 0; k < 4; k++) begin
            check("throughput_valid", m_if.m_valid_o, 1);
            @(negedge clk);
        end
        n = 0;
        while (bank_release == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("single_release", bank_release, 2'b01);
        @(negedge clk);
        check("release_width", bank_release, 2'b00);
        check("next_bank", rd_bank, 1);
        @(posedge clk); #1;
        bank_full = 2'b00;
        wait_done("single_done", 50);

        // Alternation from reset: bank 0 (3 beats) then bank 1 (2 beats)
        pulse_reset();
        @(posedge clk); #1;
        len0 = 9'd3;
        len1 = 9'd2;
        bank_full = 2'b11;
        push_frame(0, 3);
        push_frame(1, 2);
        n = 0;
        while (!(m_if.m_valid_o && m_if.m_ready_i && m_if.m_last_o) && n < 50) begin
            @(negedge clk);
            n++;
        end
        d = 0;
        do begin
            @(negedge clk);
            d++;
        end while (!rd_en && d < 10);
        check("frame_gap", d, 3);
        check("gap_bank", rd_bank, 1);
        @(posedge clk); #1;
        bank_full[0] = 1'b0;
        wait_done("alternate_done", 100);
        @(posedge clk); #1;
        bank_full = 2'b00;

        // Backpressure, bank 0, len 8
        rand_ready = 1'b1;
        run_frame("backpressure_done", 0, 8, 8);
        rand_ready = 1'b0;
        @(posedge clk); #1;
        m_if.m_ready_i = 1'b1;

        // Length edge cases
        run_frame("len0_done", 1, 0, 0);
        run_frame("len1_done", 0, 1, 1);
        run_frame("len_clamp_done", 1, DEPTH + 5, 256);

        // Reset after 3 of 8 beats on bank 0
        @(posedge clk); #1;
        len0 = 9'd8;
        bank_full = 2'b01;
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, ram_word(0, i)});
        base = n_acc;
        n = 0;
        while (n_acc < base + 3 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        rst = 1'b1;
        m_if.m_ready_i = 1'b0;
        bank_full = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", m_if.m_valid_o, 0);
        check("midrst_rd_en", rd_en, 0);
        check("midrst_release", bank_release, 0);
        check("midrst_fifo", dbg.fifo_count, 0);
        check("midrst_beats", exp_q.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_if.m_ready_i = 1'b1;
        run_frame("restart_done", 0, 8, 8);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("end_state", dbg.state, ST_IDLE);
        check("end_valid", m_if.m_valid_o, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
